muldiv_seq_ctrl: RTL

- Sequencer for the iterative RV64M multiply/divide datapath in the execute stage.
- Accepts one M-extension op from decode and drives the datapath's load and step strobes over 64 iterations (32 for W variants).
- Stalls the pipeline while the op runs and flags completion for one cycle.
- Sits beside the ALU operand-select control; the datapath itself (shift/add registers) is outside this block.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_iter_cnt.sv | 28 ++
 rtl/muldiv_seq_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV64M iterative multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam int XLEN_ITERS = 64;
  localparam int WLEN_ITERS = 32;

endpackage

// File: rtl/muldiv_iter_cnt.sv
// Loadable iteration down-counter; stops at zero and flags it.
module muldiv_iter_cnt #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load takes priority; decrement is blocked at zero so the count never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Sequencer for the iterative RV64M multiply/divide datapath.
// Optional busy-cycle performance counter: define MULDIV_PERF_CNT_EN.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for an op; dp_load/stall pulse combinationally on issue
// ST_RUN  | one dp_step per cycle until the iteration counter reaches zero
// ST_DONE | result_valid for one cycle, pipeline released
module muldiv_seq_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_ITERS,
  parameter int WLEN  = WLEN_ITERS,
  parameter int CNT_W = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [2:0]  issue_funct3,
  input  logic        issue_word,
  input  logic        divisor_zero,
  input  logic        flush,
  output logic        stall,
  output logic        dp_load,
  output logic        dp_step,
  output logic [2:0]  dp_funct3,
  output logic        dp_word,
  output logic        result_valid,
  output logic        busy
`ifdef MULDIV_PERF_CNT_EN
  ,
  output logic [31:0] perf_busy_cycles
`endif
);

  state_t           state;
  logic             issue_go;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  // A flush in the issue cycle cancels the op before anything is loaded.
  assign issue_go     = (state == ST_IDLE) && issue_valid && !flush;
  assign cnt_load_val = issue_word ? CNT_W'(WLEN - 1) : CNT_W'(XLEN - 1);
  assign cnt_dec      = (state == ST_RUN) && !cnt_zero;

  muldiv_iter_cnt #(
    .CNT_W(CNT_W)
  ) u_iter_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (issue_go),
    .load_val(cnt_load_val),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );

  // State sequencing and op latch; divide with a zero divisor skips the iterations.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      dp_funct3 <= 3'd0;
      dp_word   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue_go) begin
            dp_funct3 <= issue_funct3;
            dp_word   <= issue_word;
            state     <= (issue_funct3[2] && divisor_zero) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (flush)         state <= ST_IDLE;
          else if (cnt_zero) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode directly from state; dp_load/stall must act in the issue cycle.
  assign dp_load      = issue_go;
  assign stall        = issue_go || (state == ST_RUN);
  assign dp_step      = (state == ST_RUN);
  assign result_valid = (state == ST_DONE) && !flush;
  assign busy         = (state != ST_IDLE);

`ifdef MULDIV_PERF_CNT_EN
  // Saturating count of busy cycles, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_busy_cycles <= 32'd0;
    end else if (busy && (perf_busy_cycles != 32'hFFFF_FFFF)) begin
      perf_busy_cycles <= perf_busy_cycles + 32'd1;
    end
  end
`endif

endmodule
